sampler_pretrig: RTL and testbench
==================================

# sampler_pretrig

Parametrised multi-channel logic-analyzer sampler with a programmable pre-trigger window, edge and pattern trigger modes, and a capture-complete flag. It sits between the probe inputs and the capture RAM, and replaces the fixed 16-channel sampler. On each CE strobe it writes one sample into a circular buffer. It stops after a full buffer has been captured around the trigger point and reports where that trigger sample lives in memory.

## Interface
- WIDTH, 16: number of probe channels (sample width), 2..64
- AW, 11: capture RAM address width; buffer depth is 2^AW
- CW, $clog2(WIDTH): channel-select width (derived, not overridden)

- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- CE  in  1  sample strobe; one sample is taken per CLK edge with CE=1
- ARM  in  1  single-cycle pulse; latches configuration and starts a capture
- INPUT  in  WIDTH  probe inputs, already synchronous to CLK
- TRIG_MODE  in  3  0 immediate, 1 rising, 2 falling, 3 any edge, 4 pattern match, 5-7 never
- TRIG_CH  in  CW  channel used by the edge modes
- TRIG_MASK  in  WIDTH  bits compared in pattern mode
- TRIG_VALUE  in  WIDTH  pattern value
- PRE_CNT  in  AW  number of samples kept before the trigger sample
- Q  out  WIDTH  RAM write data
- ADDRQ  out  AW  RAM write address
- WREN  out  1  RAM write enable, one CLK per sample
- TRIGGER  out  1  one-cycle pulse coincident with the trigger sample write
- TRIG_ADDR  out  AW  address of the trigger sample
- BUSY  out  1  capture in progress
- DONE  out  1  capture complete; held until the next ARM or reset

## Operation
- FSM states: IDLE, PRE, WAIT, POST, FULL.
- ARM latches TRIG_MODE, TRIG_CH, TRIG_MASK, TRIG_VALUE and PRE_CNT. It also clears the write pointer, sample counter, prev_valid and DONE. The next state is PRE, or WAIT if PRE_CNT=0.
- ARM in any state aborts the current capture and restarts. If ARM and CE occur on the same edge, ARM wins and that sample is discarded.
- Every accepted sample (CE=1 while in PRE, WAIT or POST) is written to the current write-pointer address. The pointer then increments modulo 2^AW.
- In PRE, the trigger is ignored. After PRE_CNT writes the FSM moves to WAIT.
- In WAIT, writes continue circularly and overwrite the oldest data, so the trigger condition is evaluated on every sample.
- Trigger conditions:
  - Immediate: the first WAIT sample triggers.
  - Rising edge: prev[TRIG_CH]=0 and cur[TRIG_CH]=1.
  - Falling edge: prev[TRIG_CH]=1 and cur[TRIG_CH]=0.
  - Any edge: either of the above.
  - Pattern match: (INPUT & MASK) == (VALUE & MASK).
  - Edge modes require prev_valid. prev is the last accepted sample (including PRE samples) and prev_valid is set by the first accepted sample after ARM.
- On the trigger sample:
  - The sample is written.
  - TRIGGER pulses and TRIG_ADDR takes its address.
  - The post counter loads 2^AW-1-PRE_CNT.
  - The FSM moves to POST, or directly to FULL if the post counter is 0.
- In POST, each write decrements the post counter. When it reaches 0, the FSM moves to FULL.
- FULL: DONE=1, BUSY=0, no writes. Further CE strobes are ignored.
- Buffer layout: the oldest sample is at TRIG_ADDR-PRE_CNT (mod 2^AW). If the trigger fires before the pointer wraps, the addresses from TRIG_ADDR+1 onward hold post-trigger data only. This is expected.
- Modes 5-7 never trigger; the FSM stays in WAIT until ARM or reset.

## Timing
- All outputs are registered. Reset values: Q=0, ADDRQ=0, WREN=0, TRIGGER=0, TRIG_ADDR=0, BUSY=0, DONE=0, FSM=IDLE.
- Reset is asynchronous and clears immediately, including mid-capture. No write is issued after RST_N falls.
- Latency: a CE sample on edge n produces WREN=1, Q=INPUT and ADDRQ on edge n+1. TRIGGER and the TRIG_ADDR update are on the same edge as that write.
- BUSY rises the edge after ARM. DONE rises on the same edge as the final write and BUSY falls on that same edge.
- Back-to-back CE (CE=1 on consecutive edges) must sustain one write per CLK.
- TRIG_ADDR holds its value until the next ARM clears it to 0.

## Test plan
- Reset: pulse RST_N low in the middle of POST -> all outputs are 0 immediately. With no ARM, 20 CE strobes produce no WREN.
- Immediate capture (AW=4, PRE_CNT=0, mode 0): ARM, then 17 CE with INPUT=k -> 16 writes at ADDRQ 0..15 with Q=k. TRIGGER and TRIG_ADDR=0 come with the first write. DONE comes with the 16th write. The 17th CE produces no write.
- Rising edge with pre-trigger (AW=4, PRE_CNT=4, TRIG_CH=5, walking-one pattern with 0x0020 at sample 10) -> TRIGGER with ADDRQ=10 and TRIG_ADDR=10. Then 11 post writes, the last at ADDRQ=5 with DONE=1.
- PRE window masking (PRE_CNT=8, rising edge on ch0 at samples 3 and 9) -> no trigger at sample 3. Trigger at sample 9 with TRIG_ADDR=9.
- Pattern (MASK=0x00FF, VALUE=0x0012): INPUT=0x0013 -> no trigger. INPUT=0xAB12 -> TRIGGER.
- Re-arm: ARM during WAIT with CE=1 on the same edge -> no write on the next edge. The following write is at ADDRQ=0, DONE=0 and TRIG_ADDR=0.

Source files
------------

// File: rtl/sampler_pretrig.sv
// sampler_pretrig
//   Multi-channel logic-analyzer sampler. It sits between the probe inputs
//   and the capture RAM. Samples go into a circular buffer, with a
//   programmable pre-trigger window. The trigger can be an edge or a pattern
//   match. Capture stops once a full buffer has been taken around the
//   trigger point.
//
// Ports
//   CLK, RST_N   clock (rising edge), asynchronous active-low reset
//   CE           sample strobe, one sample per CLK edge with CE=1
//   ARM          single-cycle pulse: latch configuration, start a capture
//   INPUT        probe inputs (synchronous to CLK)
//   TRIG_MODE    0 immediate, 1 rising, 2 falling, 3 any edge, 4 pattern,
//                5-7 never
//   TRIG_CH      channel watched by the edge modes
//   TRIG_MASK    bits compared in pattern mode
//   TRIG_VALUE   pattern value
//   PRE_CNT      samples kept ahead of the trigger sample
//   Q/ADDRQ/WREN RAM write data / address / enable
//   TRIGGER      pulse coincident with the trigger sample write
//   TRIG_ADDR    RAM address of the trigger sample
//   BUSY, DONE   capture in progress / capture complete
module sampler_pretrig #(
    parameter int WIDTH = 16,
    parameter int AW    = 11,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE,
    input  logic             ARM,
    input  logic [WIDTH-1:0] INPUT,
    input  logic [2:0]       TRIG_MODE,
    input  logic [CW-1:0]    TRIG_CH,
    input  logic [WIDTH-1:0] TRIG_MASK,
    input  logic [WIDTH-1:0] TRIG_VALUE,
    input  logic [AW-1:0]    PRE_CNT,
    output logic [WIDTH-1:0] Q,
    output logic [AW-1:0]    ADDRQ,
    output logic             WREN,
    output logic             TRIGGER,
    output logic [AW-1:0]    TRIG_ADDR,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT,
        POST,
        FULL
    } state_t;

    localparam logic [AW-1:0] ONE = AW'(1);

    state_t           state, state_nxt;

    logic [2:0]       cfg_mode;
    logic [CW-1:0]    cfg_ch;
    logic [WIDTH-1:0] cfg_mask;
    logic [WIDTH-1:0] cfg_value;
    logic [AW-1:0]    cfg_pre;

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    pre_left;
    logic [AW-1:0]    post_cnt;
    logic [WIDTH-1:0] prev;
    logic             prev_valid;

    logic             accept;
    logic             hit;
    logic             rise;
    logic             fall;
    logic             trig_fire;
    logic             final_write;
    logic [AW-1:0]    post_load;

    // Samples after the trigger: 2^AW-1-PRE_CNT is the bitwise complement.
    assign post_load = ~cfg_pre;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        hit         = 1'b0;
        rise        = 1'b0;
        fall        = 1'b0;
        trig_fire   = 1'b0;
        final_write = 1'b0;

        // ARM has priority over a coincident CE, so that sample is dropped.
        accept = CE && !ARM && (state == PRE || state == WAIT || state == POST);

        rise = prev_valid && !prev[cfg_ch] &&  INPUT[cfg_ch];
        fall = prev_valid &&  prev[cfg_ch] && !INPUT[cfg_ch];

        case (cfg_mode)
            3'd0:    hit = 1'b1;
            3'd1:    hit = rise;
            3'd2:    hit = fall;
            3'd3:    hit = rise || fall;
            3'd4:    hit = ((INPUT ^ cfg_value) & cfg_mask) == '0;
            default: hit = 1'b0;
        endcase

        trig_fire = accept && (state == WAIT) && hit;

        if (ARM) begin
            state_nxt = (PRE_CNT == '0) ? WAIT : PRE;
        end else if (accept) begin
            case (state)
                PRE: begin
                    if (pre_left == ONE) begin
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (trig_fire) begin
                        if (post_load == '0) begin
                            state_nxt   = FULL;
                            final_write = 1'b1;
                        end else begin
                            state_nxt = POST;
                        end
                    end
                end
                POST: begin
                    if (post_cnt == ONE) begin
                        state_nxt   = FULL;
                        final_write = 1'b1;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q          <= '0;
            ADDRQ      <= '0;
            WREN       <= 1'b0;
            TRIGGER    <= 1'b0;
            TRIG_ADDR  <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            cfg_mode   <= '0;
            cfg_ch     <= '0;
            cfg_mask   <= '0;
            cfg_value  <= '0;
            cfg_pre    <= '0;
            wptr       <= '0;
            pre_left   <= '0;
            post_cnt   <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
        end else begin
            WREN    <= accept;
            TRIGGER <= trig_fire;

            if (ARM) begin
                cfg_mode   <= TRIG_MODE;
                cfg_ch     <= TRIG_CH;
                cfg_mask   <= TRIG_MASK;
                cfg_value  <= TRIG_VALUE;
                cfg_pre    <= PRE_CNT;
                pre_left   <= PRE_CNT;
                wptr       <= '0;
                prev_valid <= 1'b0;
                TRIG_ADDR  <= '0;
                DONE       <= 1'b0;
                BUSY       <= 1'b1;
            end else if (accept) begin
                Q          <= INPUT;
                ADDRQ      <= wptr;
                wptr       <= wptr + ONE;
                prev       <= INPUT;
                prev_valid <= 1'b1;

                if (state == PRE) begin
                    pre_left <= pre_left - ONE;
                end
                if (state == POST) begin
                    post_cnt <= post_cnt - ONE;
                end
                if (trig_fire) begin
                    TRIG_ADDR <= wptr;
                    post_cnt  <= post_load;
                end
                if (final_write) begin
                    DONE <= 1'b1;
                    BUSY <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sampler_pretrig.sv
// Directed testbench for sampler_pretrig (WIDTH=16, AW=4).
module tb_sampler_pretrig;

    localparam int WIDTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 4;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             CE = 1'b0;
    logic             ARM = 1'b0;
    logic [WIDTH-1:0] INPUT = '0;
    logic [2:0]       TRIG_MODE = '0;
    logic [CW-1:0]    TRIG_CH = '0;
    logic [WIDTH-1:0] TRIG_MASK = '0;
    logic [WIDTH-1:0] TRIG_VALUE = '0;
    logic [AW-1:0]    PRE_CNT = '0;
    logic [WIDTH-1:0] Q;
    logic [AW-1:0]    ADDRQ;
    logic             WREN;
    logic             TRIGGER;
    logic [AW-1:0]    TRIG_ADDR;
    logic             BUSY;
    logic             DONE;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    sampler_pretrig #(
        .WIDTH(WIDTH),
        .AW   (AW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CE        (CE),
        .ARM       (ARM),
        .INPUT     (INPUT),
        .TRIG_MODE (TRIG_MODE),
        .TRIG_CH   (TRIG_CH),
        .TRIG_MASK (TRIG_MASK),
        .TRIG_VALUE(TRIG_VALUE),
        .PRE_CNT   (PRE_CNT),
        .Q         (Q),
        .ADDRQ     (ADDRQ),
        .WREN      (WREN),
        .TRIGGER   (TRIGGER),
        .TRIG_ADDR (TRIG_ADDR),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one clock's worth of inputs; return 1 time unit after the edge.
    task automatic step(input logic ce, input logic arm, input logic [WIDTH-1:0] din);
        CE    = ce;
        ARM   = arm;
        INPUT = din;
        @(posedge CLK);
        #1;
        ARM = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", {Q, ADDRQ, WREN, TRIGGER, TRIG_ADDR, BUSY, DONE}, 64'h0);
        RST_N = 1'b1;

        // No ARM: CE strobes write nothing
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 16'(k));
            chk("idle_no_wren", WREN, 1'b0);
        end

        // Immediate capture, PRE_CNT=0
        TRIG_MODE = 3'd0;
        PRE_CNT   = 4'd0;
        step(1'b0, 1'b1, 16'h0);
        chk("imm_busy_after_arm", BUSY, 1'b1);
        chk("imm_no_wren_on_arm", WREN, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, 16'(k));
            chk("imm_wren", WREN, 1'b1);
            chk("imm_addr", ADDRQ, 64'(k));
            chk("imm_q", Q, 64'(k));
            chk("imm_trigger", TRIGGER, (k == 0));
            chk("imm_trig_addr", TRIG_ADDR, 64'h0);
            chk("imm_done", DONE, (k == 15));
            chk("imm_busy", BUSY, (k != 15));
        end
        step(1'b1, 1'b0, 16'd16);
        chk("imm_17th_no_write", WREN, 1'b0);
        chk("imm_done_held", DONE, 1'b1);

        // Rising edge on ch5 with 4 pre-trigger samples
        TRIG_MODE = 3'd1;
        TRIG_CH   = 4'd5;
        PRE_CNT   = 4'd4;
        step(1'b0, 1'b1, 16'h0);
        chk("rise_done_cleared", DONE, 1'b0);
        for (int k = 0; k < 22; k++) begin
            step(1'b1, 1'b0, 16'(32'd1 << ((k + 11) % 16)));
            chk("rise_wren", WREN, 1'b1);
            chk("rise_addr", ADDRQ, 64'(k % 16));
            chk("rise_trigger", TRIGGER, (k == 10));
            chk("rise_done", DONE, (k == 21));
            if (k == 10) chk("rise_trig_addr", TRIG_ADDR, 64'd10);
        end
        step(1'b1, 1'b0, 16'h0020);
        chk("rise_no_write_full", WREN, 1'b0);
        chk("rise_trig_addr_held", TRIG_ADDR, 64'd10);

        // PRE window masks an early edge on ch0
        TRIG_CH = 4'd0;
        PRE_CNT = 4'd8;
        step(1'b0, 1'b1, 16'h0);
        for (int k = 0; k < 17; k++) begin
            step(1'b1, 1'b0, ((k == 3) || (k == 9)) ? 16'h0001 : 16'h0000);
            chk("prewin_trigger", TRIGGER, (k == 9));
            if (k == 9)  chk("prewin_trig_addr", TRIG_ADDR, 64'd9);
            if (k == 15) chk("prewin_not_done", DONE, 1'b0);
            if (k == 16) chk("prewin_done", DONE, 1'b1);
        end

        // Pattern match
        TRIG_MODE  = 3'd4;
        TRIG_MASK  = 16'h00FF;
        TRIG_VALUE = 16'h0012;
        PRE_CNT    = 4'd0;
        step(1'b0, 1'b1, 16'h0);
        step(1'b1, 1'b0, 16'h0013);
        chk("pat_miss_wren", WREN, 1'b1);
        chk("pat_miss_trigger", TRIGGER, 1'b0);
        step(1'b1, 1'b0, 16'hAB12);
        chk("pat_hit_trigger", TRIGGER, 1'b1);
        chk("pat_hit_q", Q, 64'hAB12);
        chk("pat_hit_trig_addr", TRIG_ADDR, 64'd1);

        // Never-trigger mode, then re-arm during WAIT with coincident CE
        TRIG_MODE = 3'd7;
        step(1'b0, 1'b1, 16'h0);
        chk("never_trig_addr_cleared", TRIG_ADDR, 64'h0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 16'(k * 16'h1111));
            chk("never_no_trigger", TRIGGER, 1'b0);
        end
        chk("never_busy", BUSY, 1'b1);
        TRIG_MODE = 3'd0;
        step(1'b1, 1'b1, 16'h5555);
        chk("rearm_no_write", WREN, 1'b0);
        chk("rearm_done", DONE, 1'b0);
        chk("rearm_trig_addr", TRIG_ADDR, 64'h0);
        step(1'b1, 1'b0, 16'h7777);
        chk("rearm_first_wren", WREN, 1'b1);
        chk("rearm_first_addr", ADDRQ, 64'h0);
        chk("rearm_first_trigger", TRIGGER, 1'b1);
        chk("rearm_first_done", DONE, 1'b0);

        // Asynchronous reset in the middle of POST
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 16'(k));
        chk("mid_post_busy", BUSY, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_reset_outputs", {Q, ADDRQ, WREN, TRIGGER, TRIG_ADDR, BUSY, DONE}, 64'h0);
        @(posedge CLK);
        #1;
        chk("in_reset_no_wren", WREN, 1'b0);
        RST_N = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 16'hFFFF);
            chk("post_reset_no_wren", WREN, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
